// File: rtl/ps2_host_tx_if.sv
// Command handshake between a PS/2 command source and the ps2_host_tx transmitter.
// The master drives the command and request. The transmitter (slave) reports busy, done and error.
interface ps2_host_tx_if;
    logic [7:0] iCommand;
    logic       iSend;
    logic       oBusy;
    logic       oDone;
    logic       oError;

    modport master (
        output iCommand,
        output iSend,
        input  oBusy,
        input  oDone,
        input  oError
    );

    modport slave (
        input  iCommand,
        input  iSend,
        output oBusy,
        output oDone,
        output oError
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. It drives PS2_CLK/PS2_DAT open-drain alongside the receive path.
// Optional macro PS2_TX_ACK_CHECK_EN: when it is defined, a device ACK of 1 ends the frame in oError instead of oDone.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          reset_m,
    ps2_host_tx_if.slave  bus,
    inout  wire           PS2_CLK,
    inout  wire           PS2_DAT
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic             clk_oe;
    logic             dat_oe;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [3:0]       edge_cnt;
    logic [9:0]       frame_q;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_q;
`endif

    logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic ps2_dat_p0, ps2_dat_p1;
    logic fall;
    logic wd_hit;
    logic timeout;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
        return (v == WD_LIMIT) ? v : v + 1'b1;
    endfunction

    // Synchronizer stage: p1 is the synchronized pin and p2 is its previous value.
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            ps2_clk_p0 <= 1'b1;
            ps2_clk_p1 <= 1'b1;
            ps2_clk_p2 <= 1'b1;
            ps2_dat_p0 <= 1'b1;
            ps2_dat_p1 <= 1'b1;
        end else begin
            ps2_clk_p0 <= PS2_CLK;
            ps2_clk_p1 <= ps2_clk_p0;
            ps2_clk_p2 <= ps2_clk_p1;
            ps2_dat_p0 <= PS2_DAT;
            ps2_dat_p1 <= ps2_dat_p0;
        end
    end

    assign fall    = ps2_clk_p2 & ~ps2_clk_p1;
    assign wd_hit  = (wd_cnt == WD_LIMIT);
    assign timeout = wd_hit && (state == RTS || state == SHIFT || state == WAIT_IDLE);

    // Frame holds {stop, parity, d7..d0}. Bit 0 is the value for the next device edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.iSend) begin
            frame_q <= {1'b1, odd_parity(bus.iCommand), bus.iCommand};
        end else if (state == SHIFT && fall) begin
            frame_q <= {1'b1, frame_q[9:1]};
        end
    end

    // Control FSM stage
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            state    <= IDLE;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            inh_cnt  <= '0;
            wd_cnt   <= '0;
            edge_cnt <= '0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q    <= 1'b1;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (timeout) begin
                state   <= IDLE;
                clk_oe  <= 1'b0;
                dat_oe  <= 1'b0;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                wd_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        clk_oe <= 1'b0;
                        dat_oe <= 1'b0;
                        if (bus.iSend) begin
                            state   <= INHIBIT;
                            clk_oe  <= 1'b1;
                            busy_q  <= 1'b1;
                            inh_cnt <= '0;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            state  <= RTS;
                            clk_oe <= 1'b0;
                            dat_oe <= 1'b1;
                            wd_cnt <= '0;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        state    <= SHIFT;
                        edge_cnt <= '0;
                        wd_cnt   <= '0;
                    end
                    SHIFT: begin
                        if (fall) begin
                            wd_cnt   <= '0;
                            edge_cnt <= edge_cnt + 1'b1;
                            // The eleventh edge carries the device ACK and no host bit.
                            if (edge_cnt == 4'd10) begin
                                dat_oe <= 1'b0;
                                state  <= WAIT_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                                ack_q  <= ps2_dat_p1;
`endif
                            end else begin
                                dat_oe <= ~frame_q[0];
                            end
                        end else begin
                            wd_cnt <= sat_inc(wd_cnt);
                        end
                    end
                    WAIT_IDLE: begin
                        if (ps2_clk_p1 && ps2_dat_p1) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
                            done_q  <= ~ack_q;
                            error_q <= ack_q;
`else
                            done_q  <= 1'b1;
`endif
                        end else begin
                            wd_cnt <= sat_inc(wd_cnt);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        clk_oe <= 1'b0;
                        dat_oe <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.oBusy  = busy_q;
    assign bus.oDone  = done_q;
    assign bus.oError = error_q;

    assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames and a scoreboard pairs each request with its outcome.
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int HALF = 100;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] cmd;
        bit         ack;
        int         edges;
        bit         resend;
        bit         exp_err;
        bit         exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] cmd;
        bit         par;
        bit         err;
        int         edges;
    } exp_t;

    logic clk = 1'b0;
    logic reset_m = 1'b0;
    wire  ps2_clk;
    wire  ps2_dat;
    logic dev_clk_oe = 1'b0;
    logic dev_dat_oe = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_total = 0;
    int   err_total = 0;
    int   last_fall_cyc = 0;
    exp_t exp_q[$];
    vec_t vecs[5];

    ps2_host_tx_if bus();

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_oe ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_oe ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .reset_m (reset_m),
        .bus     (bus),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.oDone)  done_total <= done_total + 1;
        if (bus.oError) err_total  <= err_total + 1;
    end

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Device model: it measures the inhibit, then clocks `edges` pulses, sampling the data line on each rising edge.
    task automatic dev_frame(input int edges, input bit ack, input bit resend,
                             output logic [7:0] rx_byte, output bit rx_par,
                             output bit rx_stop, output int inh_len);
        int n;
        bit [9:0] bits;
        bits = '0;
        inh_len = 0;
        n = 0;
        while (ps2_clk == 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (ps2_clk == 1'b0 && inh_len < 10 * INH) begin
            inh_len++;
            @(negedge clk);
        end
        check("rts_dat_low", int'(ps2_dat), 0);
        repeat (20) @(negedge clk);
        for (int k = 1; k <= edges; k++) begin
            dev_clk_oe = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_dat;
            if (k == 3 && resend) begin
                bus.iCommand = 8'hAA;
                bus.iSend    = 1'b1;
            end
            dev_clk_oe = 1'b0;
            repeat (5) @(negedge clk);
            if (k == 11) dev_dat_oe = 1'b0;
            repeat (HALF / 2 - 5) @(negedge clk);
            if (k == 3 && resend) bus.iSend = 1'b0;
            if (k == 10 && !ack) dev_dat_oe = 1'b1;
            repeat (HALF - HALF / 2) @(negedge clk);
        end
        dev_dat_oe = 1'b0;
        rx_byte = bits[7:0];
        rx_par  = bits[8];
        rx_stop = bits[9];
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got_e;
        logic [7:0] rx_byte;
        bit rx_par, rx_stop, got;
        bit p_done, p_err, p_busy;
        int inh_len, gaps, pulse_cyc, extra;
        e.cmd   = v.cmd;
        e.par   = v.exp_par;
        e.err   = v.exp_err;
        e.edges = v.edges;
        exp_q.push_back(e);
        got_e = e;
        got = 1'b0;
        gaps = 0;
        pulse_cyc = 0;
        p_done = 1'b0;
        p_err = 1'b0;
        p_busy = 1'b0;
        @(negedge clk);
        bus.iCommand = v.cmd;
        bus.iSend    = 1'b1;
        @(negedge clk);
        bus.iSend    = 1'b0;
        check("busy_after_accept", int'(bus.oBusy), 1);
        fork
            dev_frame(v.edges, v.ack, v.resend, rx_byte, rx_par, rx_stop, inh_len);
            begin
                for (int i = 0; i < 8000 && !got; i++) begin
                    @(negedge clk);
                    if (bus.oDone || bus.oError) begin
                        got       = 1'b1;
                        p_done    = bus.oDone;
                        p_err     = bus.oError;
                        p_busy    = bus.oBusy;
                        pulse_cyc = cyc;
                    end else if (!bus.oBusy) begin
                        gaps++;
                    end
                end
                if (!got) begin
                    check("result_arrived", 0, 1);
                    exp_q.delete();
                end else begin
                    got_e = exp_q.pop_front();
                    check("result_error", int'(p_err), int'(got_e.err));
                    check("result_done", int'(p_done), int'(!got_e.err));
                    check("busy_at_pulse", int'(p_busy), 0);
                    @(negedge clk);
                    check("pulse_width", int'(bus.oDone || bus.oError), 0);
                end
            end
        join
        check("inhibit_len", inh_len, INH);
        check("busy_gaps", gaps, 0);
        if (v.edges == 11) begin
            check("rx_byte", int'(rx_byte), int'(got_e.cmd));
            check("rx_parity", int'(rx_par), int'(got_e.par));
            check("rx_stop", int'(rx_stop), 1);
        end else begin
            check("timeout_delay_in_range",
                  int'((pulse_cyc - last_fall_cyc) >= TO && (pulse_cyc - last_fall_cyc) <= TO + 10), 1);
            check("timeout_clk_released", int'(ps2_clk), 1);
            check("timeout_dat_released", int'(ps2_dat), 1);
        end
        if (v.resend) begin
            extra = 0;
            repeat (300) begin
                @(negedge clk);
                if (ps2_clk == 1'b0 || bus.oBusy) extra++;
            end
            check("resend_ignored", extra, 0);
        end
    endtask

    initial begin
        logic [7:0] rb;
        bit rp, rs;
        int il, base;
        vec_t post;
        bus.iCommand = '0;
        bus.iSend    = 1'b0;
        vecs[0] = '{8'hED, 1'b0, 11, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 1'b0, 11, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'hF4, 1'b1, 11, 1'b0, ACK_CHK, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 5,  1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 1'b0, 11, 1'b1, 1'b0, 1'b0};
        post    = '{8'hFF, 1'b0, 11, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.oBusy), 0);
        check("reset_done", int'(bus.oDone), 0);
        check("reset_error", int'(bus.oError), 0);
        check("reset_clk_released", int'(ps2_clk), 1);
        check("reset_dat_released", int'(ps2_dat), 1);
        reset_m = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (20) @(negedge clk);
        end

        // Reset while the host drives d3 = 0 after the fourth device edge
        @(negedge clk);
        bus.iCommand = 8'h30;
        bus.iSend    = 1'b1;
        @(negedge clk);
        bus.iSend    = 1'b0;
        dev_frame(4, 1'b0, 1'b0, rb, rp, rs, il);
        check("pre_reset_dat_driven", int'(ps2_dat), 0);
        check("pre_reset_busy", int'(bus.oBusy), 1);
        base = done_total + err_total;
        #2 reset_m = 1'b0;
        #1;
        check("async_reset_dat", int'(ps2_dat), 1);
        check("async_reset_clk", int'(ps2_clk), 1);
        check("async_reset_busy", int'(bus.oBusy), 0);
        check("async_reset_pulses", int'(bus.oDone || bus.oError), 0);
        repeat (20) @(negedge clk);
        reset_m = 1'b1;
        repeat (50) @(negedge clk);
        check("no_pulse_after_reset", done_total + err_total, base);
        run_vec(post);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte from the FPGA to the keyboard, such as 0xFF reset, 0xED set-LEDs or 0xF4 enable. It shares the PS2_CLK/PS2_DAT pins with the existing PS/2 receive path and drives both lines open-drain. The receiver must ignore the bus while `oBusy` is high. It implements inhibit, request-to-send, 11-clock bit shifting, device ACK and timeout, and reports completion or error with single-cycle pulses.

## Interface
- `INHIBIT_CYCLES`, default 6000: `clk` cycles PS2_CLK is held low before request-to-send (120 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles allowed between device clock falling edges, and while waiting for bus idle (15 ms at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `reset_m` in 1: asynchronous, active-low reset.
- `iCommand` in 8: byte to send. Sampled on the accept cycle.
- `iSend` in 1: request. Accepted only in IDLE.
- `oBusy` out 1: high from the accept cycle through the final state. Reset value 0.
- `oDone` out 1: one-cycle pulse on successful completion. Reset value 0.
- `oError` out 1: one-cycle pulse on timeout or NACK. Reset value 0.
- `PS2_CLK` inout 1: driven 0 when the clock output enable is set, otherwise Z. Resets to Z.
- `PS2_DAT` inout 1: driven 0 when the data output enable is set, otherwise Z. Resets to Z.

## Operation
- **Input conditioning:** both pin inputs pass through a 2-flop synchronizer. A falling edge is registered when the synchronized value is 1 on one cycle and 0 on the next.
- **Frame format:** start bit 0, data d0..d7 LSB first, odd parity (XOR of data, inverted), stop bit 1, then device ACK 0.
- **IDLE:** both lines released. On `iSend`=1, latch `iCommand`, compute parity, set `oBusy`, go to INHIBIT.
- **INHIBIT:** drive PS2_CLK low for exactly INHIBIT_CYCLES cycles, then go to RTS.
- **RTS:** drive PS2_DAT low and release PS2_CLK in the same cycle. Clear the edge counter and go to SHIFT.
- **SHIFT:** count device falling edges n = 1..11.
  - n = 1..8: drive data bit d(n-1).
  - n = 9: drive parity.
  - n = 10: release PS2_DAT (stop bit).
  - n = 11: sample synchronized PS2_DAT as ACK and go to WAIT_IDLE.
  - Driving a bit value of 1 means releasing the line.
- **WAIT_IDLE:** wait until synchronized PS2_CLK and PS2_DAT are both 1. Then pulse `oDone` (ACK was 0) or `oError` (ACK was 1), clear `oBusy`, return to IDLE.
- **Timeout:** a watchdog counter clears on every device falling edge and on every state entry, and counts in RTS, SHIFT and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: release both lines, pulse `oError`, clear `oBusy`, go to IDLE.
- **Boundary conditions:**
  - `iSend` while busy is ignored. The command is not queued.
  - `iSend` held high after completion starts a new transfer in the cycle after the return to IDLE.
  - Device edges seen in IDLE or INHIBIT are ignored.
  - Reset asserted mid-transfer immediately releases both lines, clears all counters and returns to IDLE with no `oDone`/`oError` pulse.
  - A parity or ACK result never stalls the FSM. Every path ends in IDLE.

## Timing
- Accept cycle to PS2_CLK low: 1 cycle (registered output enables).
- PS2_CLK low duration: INHIBIT_CYCLES cycles exactly.
- After each device falling edge, the new data value appears on the pin 3 cycles after the pin edge (2 synchronizer cycles plus 1 register).
- ACK is sampled 2 cycles after the 11th pin falling edge.
- `oDone`/`oError` fire 1 cycle after the bus-idle condition is detected. `oBusy` falls in that same cycle.
- The watchdog counter is sized to hold TIMEOUT_CYCLES (clog2) and saturates; it does not wrap.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined: ACK is checked as in Operation; ACK=1 produces `oError`.
- Not defined: the ACK sample is ignored and a completed 11-edge frame always ends in `oDone`. Timeout errors still apply.

## Test plan
Bench uses INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000, and a device model clocking PS2_CLK with a 200-cycle period.
- **Send 0xED, device ACKs:** PS2_CLK is low for 50 cycles. The model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1. `oDone` pulses once, `oBusy` covers the whole transfer, `oError` stays 0.
- **Send 0x00:** parity bit is 1. The device-decoded byte is 0x00. `oDone` pulses.
- **Send 0xF4, device ACK=1:** with the macro, `oError` pulses. Without the macro, `oDone` pulses.
- **Device stops clocking after 5 edges:** `oError` pulses 2000 cycles after the last edge. Both lines return to Z and the FSM is in IDLE.
- **`iSend` pulsed again during SHIFT:** ignored. Exactly one frame is seen by the device.
- **`reset_m` low during bit 4:** both lines go to Z asynchronously, outputs read 0, and no pulse occurs. A new `iSend` of 0xFF after reset completes with `oDone`.
